freq_div_multi: RTL

FREQ_DIV_MULTI -- requirements
Module: freq_div_multi

---
 rtl/freq_div_multi.sv | 86 ++++++++
 1 files changed

// File: rtl/freq_div_multi.sv
// Multi-channel programmable clock divider: NCH independent square-wave outputs with glitch-free divisor reload.
// Latency: all outputs registered; clk_out/tick change on the clock edge that ends a half-period; sync takes effect on the next edge.
// Backpressure: none; en stalls a channel in place, and loads wait for a period boundary unless sync forces them in.
module freq_div_multi #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 25,
  parameter int DEFAULT_HP = 2500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*CNT_W-1:0] half_div,
  input  logic [NCH-1:0]       ld,
  input  logic                 sync,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       pend
);

  localparam logic [CNT_W-1:0] HP_RST = CNT_W'(DEFAULT_HP);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hp;
    logic [CNT_W-1:0] pdiv;
    logic [CNT_W-1:0] div_raw;
    logic [CNT_W-1:0] div_in;
    logic             wrap;
    logic             clk_q;
    logic             tick_q;
    logic             pend_q;

    // A zero half-period has no meaning, so it is promoted to 1 (clk/2).
    assign div_raw = half_div[g*CNT_W +: CNT_W];
    assign div_in  = (div_raw == '0) ? ONE : div_raw;

    // hp only changes when cnt returns to 0, so cnt never overruns hp-1.
    assign wrap = en[g] && (cnt == hp - ONE);

    // Channel state: sync beats wrap/en; a new divisor swaps in only at a half-period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        hp     <= HP_RST;
        pdiv   <= HP_RST;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (sync) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
        if (ld[g]) begin
          hp   <= div_in;
          pdiv <= div_in;
        end else if (pend_q) begin
          hp <= pdiv;
        end
      end else begin
        tick_q <= wrap & ~clk_q;
        if (wrap) begin
          cnt   <= '0;
          clk_q <= ~clk_q;
          if (pend_q) begin
            hp     <= pdiv;
            pend_q <= 1'b0;
          end
        end else if (en[g]) begin
          cnt <= cnt + ONE;
        end
        // A load in the wrap cycle lands after the swap above, so it stays pending.
        if (ld[g]) begin
          pdiv   <= div_in;
          pend_q <= 1'b1;
        end
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pend[g]    = pend_q;
  end

endmodule
